// File: rtl/ram_arbiter.sv
// Two-master arbiter for a single shared RAM port: the loader is m0 and the CPU is m1.
// Each transaction runs IDLE -> ACCESS -> RESP and is bounded by a wait timeout.
module ram_arbiter #(
  parameter int TIMEOUT    = 255,
  parameter int FIXED_PRIO = 0,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_cs,
  input  logic              m0_we,
  input  logic              m0_oe,
  input  logic [31:0]       m0_addr,
  input  logic [DATA_W-1:0] m0_d_in,
  input  logic [1:0]        m0_size,
  output logic [DATA_W-1:0] m0_d_out,
  output logic              m0_ready,
  output logic              m0_err,
  input  logic              m1_cs,
  input  logic              m1_we,
  input  logic              m1_oe,
  input  logic [31:0]       m1_addr,
  input  logic [DATA_W-1:0] m1_d_in,
  input  logic [1:0]        m1_size,
  output logic [DATA_W-1:0] m1_d_out,
  output logic              m1_ready,
  output logic              m1_err,
  output logic [31:0]       ram_addr,
  output logic [DATA_W-1:0] ram_d_in,
  output logic              ram_cs,
  output logic              ram_we,
  output logic              ram_oe,
  output logic [1:0]        ram_size,
  input  logic [DATA_W-1:0] ram_d_out,
  input  logic              ram_done,
  output logic [1:0]        grant
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [7:0] TMO = TIMEOUT[7:0];

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [1:0]        state;
  logic [1:0]        grant_r;
  logic              last_grant;
  logic [7:0]        wait_cnt;
  logic              err_flag;

  logic [31:0]       addr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic              we_p0;
  logic              oe_p0;
  logic [1:0]        size_p0;

  logic              req_any;
  logic              pick_m1;
  logic [31:0]       sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;
  logic              sel_oe;
  logic [1:0]        sel_size;
  logic [7:0]        cnt_next;
  logic              timed_out;
  logic              in_access;
  logic              in_resp;

  assign req_any = m0_cs | m1_cs;

  // last_grant = 1 means m1 was served last, so m0 wins the next tie in round-robin mode.
  always_comb begin
    pick_m1 = 1'b0;
    if (m0_cs && m1_cs) begin
      pick_m1 = (FIXED_PRIO == 0) && !last_grant;
    end else begin
      pick_m1 = m1_cs;
    end
  end

  always_comb begin
    sel_addr  = pick_m1 ? m1_addr : m0_addr;
    sel_wdata = pick_m1 ? m1_d_in : m0_d_in;
    sel_we    = pick_m1 ? m1_we   : m0_we;
    sel_oe    = pick_m1 ? m1_oe   : m0_oe;
    sel_size  = pick_m1 ? m1_size : m0_size;
  end

  assign cnt_next  = sat_inc(wait_cnt);
  assign timed_out = (cnt_next == TMO);

  // Control state: arbitration, wait counter and response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      grant_r    <= 2'b00;
      last_grant <= 1'b1;
      wait_cnt   <= 8'd0;
      err_flag   <= 1'b0;
      m0_d_out   <= '0;
      m1_d_out   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_any) begin
            state    <= S_ACCESS;
            grant_r  <= pick_m1 ? 2'b10 : 2'b01;
            wait_cnt <= 8'd0;
            err_flag <= 1'b0;
          end else begin
            grant_r  <= 2'b00;
          end
        end
        S_ACCESS: begin
          if (ram_done) begin
            state    <= S_RESP;
            err_flag <= 1'b0;
            if (!we_p0) begin
              if (grant_r[0]) m0_d_out <= ram_d_out;
              else            m1_d_out <= ram_d_out;
            end
          end else begin
            wait_cnt <= cnt_next;
            if (timed_out) begin
              state    <= S_RESP;
              err_flag <= 1'b1;
            end
          end
        end
        S_RESP: begin
          state      <= S_IDLE;
          grant_r    <= 2'b00;
          last_grant <= grant_r[1];
        end
        default: begin
          state   <= S_IDLE;
          grant_r <= 2'b00;
        end
      endcase
    end
  end

  // Operand capture: the winner's request is frozen for the whole ACCESS state.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && req_any) begin
      addr_p0  <= sel_addr;
      wdata_p0 <= sel_wdata;
      we_p0    <= sel_we;
      oe_p0    <= sel_oe & ~sel_we;
      size_p0  <= sel_size;
    end
  end

  // RAM and master outputs decode from registered state only.
  assign in_access = (state == S_ACCESS);
  assign in_resp   = (state == S_RESP);

  assign ram_cs   = in_access;
  assign ram_we   = in_access & we_p0;
  assign ram_oe   = in_access & oe_p0;
  assign ram_addr = in_access ? addr_p0  : '0;
  assign ram_d_in = in_access ? wdata_p0 : '0;
  assign ram_size = in_access ? size_p0  : 2'b00;

  assign grant    = grant_r;
  assign m0_ready = in_resp & grant_r[0];
  assign m1_ready = in_resp & grant_r[1];
  assign m0_err   = in_resp & grant_r[0] & err_flag;
  assign m1_err   = in_resp & grant_r[1] & err_flag;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a round-robin instance and a fixed-priority
// instance share stimulus; both use TIMEOUT=4.
module tb_ram_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_cs, m0_we, m0_oe, m1_cs, m1_we, m1_oe;
  logic [31:0] m0_addr, m0_d_in, m1_addr, m1_d_in;
  logic [1:0]  m0_size, m1_size;
  logic [31:0] ram_d_out;
  logic        ram_done;

  logic [31:0] m0_d_out, m1_d_out, ram_addr, ram_d_in;
  logic        m0_ready, m0_err, m1_ready, m1_err;
  logic        ram_cs, ram_we, ram_oe;
  logic [1:0]  ram_size, grant;

  logic [31:0] fx_m0_d_out, fx_m1_d_out, fx_ram_addr, fx_ram_d_in;
  logic        fx_m0_ready, fx_m0_err, fx_m1_ready, fx_m1_err;
  logic        fx_ram_cs, fx_ram_we, fx_ram_oe;
  logic [1:0]  fx_ram_size, fx_grant;

  int n_checks = 0;
  int n_fail   = 0;

  ram_arbiter #(.TIMEOUT(4), .FIXED_PRIO(0), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_cs(m0_cs), .m0_we(m0_we), .m0_oe(m0_oe), .m0_addr(m0_addr),
    .m0_d_in(m0_d_in), .m0_size(m0_size), .m0_d_out(m0_d_out),
    .m0_ready(m0_ready), .m0_err(m0_err),
    .m1_cs(m1_cs), .m1_we(m1_we), .m1_oe(m1_oe), .m1_addr(m1_addr),
    .m1_d_in(m1_d_in), .m1_size(m1_size), .m1_d_out(m1_d_out),
    .m1_ready(m1_ready), .m1_err(m1_err),
    .ram_addr(ram_addr), .ram_d_in(ram_d_in), .ram_cs(ram_cs),
    .ram_we(ram_we), .ram_oe(ram_oe), .ram_size(ram_size),
    .ram_d_out(ram_d_out), .ram_done(ram_done), .grant(grant)
  );

  ram_arbiter #(.TIMEOUT(4), .FIXED_PRIO(1), .DATA_W(32)) dut_fx (
    .clk(clk), .rst(rst),
    .m0_cs(m0_cs), .m0_we(m0_we), .m0_oe(m0_oe), .m0_addr(m0_addr),
    .m0_d_in(m0_d_in), .m0_size(m0_size), .m0_d_out(fx_m0_d_out),
    .m0_ready(fx_m0_ready), .m0_err(fx_m0_err),
    .m1_cs(m1_cs), .m1_we(m1_we), .m1_oe(m1_oe), .m1_addr(m1_addr),
    .m1_d_in(m1_d_in), .m1_size(m1_size), .m1_d_out(fx_m1_d_out),
    .m1_ready(fx_m1_ready), .m1_err(fx_m1_err),
    .ram_addr(fx_ram_addr), .ram_d_in(fx_ram_d_in), .ram_cs(fx_ram_cs),
    .ram_we(fx_ram_we), .ram_oe(fx_ram_oe), .ram_size(fx_ram_size),
    .ram_d_out(ram_d_out), .ram_done(ram_done), .grant(fx_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    m0_cs = 0; m0_we = 0; m0_oe = 0; m0_addr = 0; m0_d_in = 0; m0_size = 0;
    m1_cs = 0; m1_we = 0; m1_oe = 0; m1_addr = 0; m1_d_in = 0; m1_size = 0;
    ram_d_out = 0; ram_done = 0;
    tick();
    tick();

    check_eq("rst_grant", grant, 2'b00);
    check_eq("rst_ram_cs", ram_cs, 1'b0);
    check_eq("rst_ram_addr", ram_addr, 32'h0);
    check_eq("rst_m0_d_out", m0_d_out, 32'h0);
    check_eq("rst_m1_ready", m1_ready, 1'b0);
    rst = 1'b1;
    tick();
    check_eq("idle_ram_cs", ram_cs, 1'b0);
    check_eq("idle_grant", grant, 2'b00);

    // m1 read of 0x100, ram_done in the third ACCESS cycle
    m1_cs = 1; m1_we = 0; m1_oe = 1; m1_addr = 32'h100; m1_size = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("rd_ram_cs", ram_cs, 1'b1);
      check_eq("rd_ram_addr", ram_addr, 32'h100);
      check_eq("rd_ram_oe", ram_oe, 1'b1);
      check_eq("rd_ram_we", ram_we, 1'b0);
      check_eq("rd_grant", grant, 2'b10);
      check_eq("rd_no_ready", m1_ready, 1'b0);
      if (i == 2) begin
        ram_done = 1; ram_d_out = 32'hDEADBEEF;
      end
    end
    tick();
    ram_done = 0; ram_d_out = 32'h0;
    check_eq("rd_m1_ready", m1_ready, 1'b1);
    check_eq("rd_m1_err", m1_err, 1'b0);
    check_eq("rd_m0_ready", m0_ready, 1'b0);
    check_eq("rd_m1_d_out", m1_d_out, 32'hDEADBEEF);
    check_eq("rd_resp_cs", ram_cs, 1'b0);
    m1_cs = 0;
    tick();
    check_eq("rd_ready_drop", m1_ready, 1'b0);
    check_eq("rd_grant_idle", grant, 2'b00);
    check_eq("rd_hold_d_out", m1_d_out, 32'hDEADBEEF);

    // m0 write with we=oe=1, size 11, minimum latency
    m0_cs = 1; m0_we = 1; m0_oe = 1; m0_addr = 32'h40; m0_d_in = 32'h12345678; m0_size = 2'b11;
    tick();
    check_eq("wr_ram_we", ram_we, 1'b1);
    check_eq("wr_ram_oe", ram_oe, 1'b0);
    check_eq("wr_ram_d_in", ram_d_in, 32'h12345678);
    check_eq("wr_ram_size", ram_size, 2'b11);
    check_eq("wr_ram_addr", ram_addr, 32'h40);
    check_eq("wr_grant", grant, 2'b01);
    ram_done = 1; ram_d_out = 32'hCAFEF00D;
    tick();
    ram_done = 0; ram_d_out = 32'h0;
    check_eq("wr_m0_ready", m0_ready, 1'b1);
    check_eq("wr_m0_err", m0_err, 1'b0);
    check_eq("wr_m0_d_out", m0_d_out, 32'h0);
    check_eq("wr_m1_d_out", m1_d_out, 32'hDEADBEEF);
    check_eq("wr_resp_we", ram_we, 1'b0);
    m0_cs = 0; m0_we = 0; m0_oe = 0;
    tick();
    check_eq("wr_idle_ready", m0_ready, 1'b0);

    // contention after reset: round-robin alternates, fixed priority keeps m0
    do_reset();
    m0_cs = 1; m0_we = 0; m0_oe = 1; m0_addr = 32'h10;
    m1_cs = 1; m1_we = 0; m1_oe = 1; m1_addr = 32'h20;
    ram_done = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("rr_grant", grant, (k % 2 == 0) ? 2'b01 : 2'b10);
      check_eq("fx_grant", fx_grant, 2'b01);
      check_eq("rr_addr", ram_addr, (k % 2 == 0) ? 32'h10 : 32'h20);
      ram_d_out = 32'hA0 + k;
      tick();
      check_eq("rr_m0_ready", m0_ready, (k % 2 == 0) ? 1'b1 : 1'b0);
      check_eq("rr_m1_ready", m1_ready, (k % 2 == 0) ? 1'b0 : 1'b1);
      check_eq("fx_m0_ready", fx_m0_ready, 1'b1);
      check_eq("fx_m1_ready", fx_m1_ready, 1'b0);
      if (k % 2 == 0) check_eq("rr_m0_d_out", m0_d_out, 32'hA0 + k);
      else            check_eq("rr_m1_d_out", m1_d_out, 32'hA0 + k);
      if (k == 3) begin
        m0_cs = 0; m1_cs = 0;
      end
      tick();
      check_eq("rr_idle_grant", grant, 2'b00);
    end
    ram_done = 0; ram_d_out = 32'h0;

    // timeout: ram_done never arrives
    m1_cs = 1; m1_we = 0; m1_oe = 1; m1_addr = 32'h200;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("to_ram_cs", ram_cs, 1'b1);
      check_eq("to_no_ready", m1_ready, 1'b0);
    end
    tick();
    check_eq("to_m1_ready", m1_ready, 1'b1);
    check_eq("to_m1_err", m1_err, 1'b1);
    check_eq("to_ram_cs_drop", ram_cs, 1'b0);
    check_eq("to_m1_d_out", m1_d_out, 32'hA3);
    m1_cs = 0;
    tick();
    check_eq("to_err_drop", m1_err, 1'b0);
    check_eq("to_idle_grant", grant, 2'b00);

    // ram_done on the same cycle the counter reaches TIMEOUT
    m0_cs = 1; m0_we = 0; m0_oe = 1; m0_addr = 32'h300;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("race_ram_cs", ram_cs, 1'b1);
      if (i == 3) begin
        ram_done = 1; ram_d_out = 32'h55AA55AA;
      end
    end
    tick();
    ram_done = 0; ram_d_out = 32'h0;
    check_eq("race_m0_ready", m0_ready, 1'b1);
    check_eq("race_m0_err", m0_err, 1'b0);
    check_eq("race_m0_d_out", m0_d_out, 32'h55AA55AA);
    check_eq("race_m1_d_out", m1_d_out, 32'hA3);
    m0_cs = 0;
    tick();

    // reset in the second ACCESS cycle aborts, held request restarts
    m1_cs = 1; m1_we = 0; m1_oe = 1; m1_addr = 32'h400;
    tick();
    check_eq("ab_ram_cs", ram_cs, 1'b1);
    tick();
    check_eq("ab_ram_cs2", ram_cs, 1'b1);
    #2 rst = 1'b0;
    #1;
    check_eq("ab_ram_cs_rst", ram_cs, 1'b0);
    check_eq("ab_ram_addr_rst", ram_addr, 32'h0);
    check_eq("ab_grant_rst", grant, 2'b00);
    check_eq("ab_m0_d_out_rst", m0_d_out, 32'h0);
    check_eq("ab_m1_d_out_rst", m1_d_out, 32'h0);
    tick();
    check_eq("ab_no_ready", m1_ready, 1'b0);
    check_eq("ab_no_err", m1_err, 1'b0);
    rst = 1'b1;
    tick();
    check_eq("ab_restart_grant", grant, 2'b10);
    check_eq("ab_restart_addr", ram_addr, 32'h400);
    ram_done = 1; ram_d_out = 32'h77;
    tick();
    ram_done = 0; ram_d_out = 32'h0;
    check_eq("ab_m1_ready", m1_ready, 1'b1);
    check_eq("ab_m1_d_out", m1_d_out, 32'h77);
    m1_cs = 0;
    tick();
    check_eq("ab_idle_grant", grant, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
